// File: rtl/ttl_inverter_scan_ctrl_if.sv
// ttl_inverter_scan_ctrl_if
//   Bus between the inverter-bank scan sequencer and its surroundings.
//   Signals (named from the sequencer's point of view):
//     Start          run request
//     Y_in           outputs returned from the inverter bank
//     A_out          pattern driven onto the inverter bank inputs
//     Busy           sequencer is driving/settling/checking
//     Done           run finished
//     Pass           valid with Done; high iff Fail_Mask is all zero
//     Fail_Mask      sticky per-channel mismatch flags
//     Pattern_Index  index of the current or last pattern
//   Modports: master = controlling side / bank, slave = sequencer.
interface ttl_inverter_scan_ctrl_if #(
  parameter int unsigned BLOCKS = 7
);
  localparam int unsigned IDX_W = $clog2(BLOCKS + 4);

  logic              Start;
  logic [BLOCKS-1:0] Y_in;
  logic [BLOCKS-1:0] A_out;
  logic              Busy;
  logic              Done;
  logic              Pass;
  logic [BLOCKS-1:0] Fail_Mask;
  logic [IDX_W-1:0]  Pattern_Index;

  modport master (
    output Start, Y_in,
    input  A_out, Busy, Done, Pass, Fail_Mask, Pattern_Index
  );

  modport slave (
    input  Start, Y_in,
    output A_out, Busy, Done, Pass, Fail_Mask, Pattern_Index
  );
endinterface

// File: rtl/ttl_inverter_scan_ctrl.sv
// ttl_inverter_scan_ctrl
//   Built-in self-test sequencer for a bank of BLOCKS inverter channels.
//   On Start it walks BLOCKS+4 patterns (all ones, all zeros, walking one,
//   alternating 1010.. with bit0=1, and its complement) onto the bank,
//   waits SETTLE_CYCLES, then checks Y == ~A, accumulating a per-channel
//   fail mask. Each pattern costs SETTLE_CYCLES+2 cycles.
//   Ports:
//     Clk    clock, rising edge
//     Clear  asynchronous active-high reset
//     bus    ttl_inverter_scan_ctrl_if.slave (Start, Y_in, A_out, Busy,
//            Done, Pass, Fail_Mask, Pattern_Index)
//   Optional build macro TTL_SCAN_STOP_ON_FAIL_EN: when defined, the first
//   CHECK with any mismatch ends the run immediately, freezing
//   Pattern_Index and A_out at the failing pattern.
module ttl_inverter_scan_ctrl #(
  parameter int unsigned BLOCKS        = 7,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Clear,
  ttl_inverter_scan_ctrl_if.slave bus
);

  localparam int unsigned NUM_PATTERNS = BLOCKS + 4;
  localparam int unsigned IDX_W        = $clog2(NUM_PATTERNS);
  localparam int unsigned CNT_W        = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BLOCKS-1:0] a_q, a_d;
  logic [BLOCKS-1:0] fail_q, fail_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLOCKS-1:0] mism;

  function automatic logic [BLOCKS-1:0] pattern(input logic [IDX_W-1:0] idx);
    logic [BLOCKS-1:0] alt;
    logic [BLOCKS-1:0] res;
    alt = '0;
    for (int unsigned i = 0; i < BLOCKS; i++) begin
      alt[i] = ~i[0];
    end
    if (idx == '0) begin
      res = '1;
    end else if (idx == IDX_W'(1)) begin
      res = '0;
    end else if (idx <= IDX_W'(BLOCKS + 1)) begin
      res = BLOCKS'(1) << (idx - IDX_W'(2));
    end else if (idx == IDX_W'(BLOCKS + 2)) begin
      res = alt;
    end else begin
      res = ~alt;
    end
    return res;
  endfunction

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      fail_q  <= fail_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    fail_d  = fail_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // A channel mismatches when its output equals its input.
    mism    = ~(bus.Y_in ^ a_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          fail_d  = '0;
          idx_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = pattern(idx_q);
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        fail_d = fail_q | mism;
`ifdef TTL_SCAN_STOP_ON_FAIL_EN
        // Nothing has failed before this CHECK, so fail_d holds only this
        // pattern's mismatches when we stop here.
        if (|mism) begin
          state_d = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_DRIVE;
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_DRIVE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.A_out         = a_q;
  assign bus.Fail_Mask     = fail_q;
  assign bus.Pattern_Index = idx_q;
  assign bus.Busy          = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign bus.Done          = (state_q == S_DONE);
  assign bus.Pass          = (state_q == S_DONE) && (fail_q == '0);

endmodule

// File: tb/tb_ttl_inverter_scan_ctrl.sv
module tb_ttl_inverter_scan_ctrl;

  logic Clk = 1'b0;
  logic Clear;

  ttl_inverter_scan_ctrl_if #(.BLOCKS(7)) bus0 ();
  ttl_inverter_scan_ctrl_if #(.BLOCKS(7)) bus1 ();

  ttl_inverter_scan_ctrl #(.BLOCKS(7), .SETTLE_CYCLES(2)) dut0 (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus0)
  );

  ttl_inverter_scan_ctrl #(.BLOCKS(7), .SETTLE_CYCLES(0)) dut1 (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus1)
  );

  always #5 Clk = ~Clk;

  localparam logic [6:0] PAT [11] = '{7'h7F, 7'h00, 7'h01, 7'h02, 7'h04, 7'h08,
                                      7'h10, 7'h20, 7'h40, 7'h55, 7'h2A};

  // Inverter bank models: fast bank rise 2 / fall 3, slow bank 15 (> 1 period).
  logic [6:0] y0_fast = '1;
  logic [6:0] y1_fast = '1;
  logic [6:0] y1_slow = '1;
  logic [6:0] stuck0  = '0;
  logic       slow1   = 1'b0;

  for (genvar g = 0; g < 7; g++) begin : g_bank
    always @(bus0.A_out[g]) begin
      if (bus0.A_out[g] === 1'b1) y0_fast[g] <= #3 1'b0;
      else                        y0_fast[g] <= #2 1'b1;
    end
    always @(bus1.A_out[g]) begin
      if (bus1.A_out[g] === 1'b1) y1_fast[g] <= #3 1'b0;
      else                        y1_fast[g] <= #2 1'b1;
    end
    always @(bus1.A_out[g]) begin
      y1_slow[g] <= #15 ~bus1.A_out[g];
    end
  end

  assign bus0.Y_in = y0_fast & ~stuck0;
  assign bus1.Y_in = slow1 ? y1_slow : y1_fast;

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (bus0.Done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (bus1.Done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    bus0.Start = 1'b0;
    bus1.Start = 1'b0;
    #12;
    vectors++; if (bus0.A_out !== 7'h00) begin miscompares++; $display("FAIL reset_a: got %b want 0000000", bus0.A_out); end
    vectors++; if (bus0.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus0.Busy); end
    vectors++; if (bus0.Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus0.Done); end
    vectors++; if (bus0.Pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", bus0.Pass); end
    vectors++; if (bus0.Fail_Mask !== 7'h00) begin miscompares++; $display("FAIL reset_mask: got %b want 0000000", bus0.Fail_Mask); end
    vectors++; if (bus0.Pattern_Index !== 4'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", bus0.Pattern_Index); end
    vectors++; if (bus1.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b want 0", bus1.Busy); end
    @(negedge Clk);
    Clear = 1'b0;
    tick();
  endtask

  task automatic test_patterns();
    stuck0 = '0;
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    vectors++; if (bus0.Busy !== 1'b1) begin miscompares++; $display("FAIL pat_busy_edge0: got %b want 1", bus0.Busy); end
    for (int k = 0; k < 11; k++) begin
      tick();
      vectors++; if (bus0.A_out !== PAT[k]) begin miscompares++; $display("FAIL pat_a[%0d]: got %b want %b", k, bus0.A_out, PAT[k]); end
      vectors++; if (bus0.Pattern_Index !== 4'(k)) begin miscompares++; $display("FAIL pat_idx[%0d]: got %0d want %0d", k, bus0.Pattern_Index, k); end
      vectors++; if (bus0.Done !== 1'b0) begin miscompares++; $display("FAIL pat_done_early[%0d]: got %b want 0", k, bus0.Done); end
      tick(); tick(); tick();
    end
    vectors++; if (bus0.Done !== 1'b1) begin miscompares++; $display("FAIL good_done_edge44: got %b want 1", bus0.Done); end
    vectors++; if (bus0.Busy !== 1'b0) begin miscompares++; $display("FAIL good_busy: got %b want 0", bus0.Busy); end
    vectors++; if (bus0.Pass !== 1'b1) begin miscompares++; $display("FAIL good_pass: got %b want 1", bus0.Pass); end
    vectors++; if (bus0.Fail_Mask !== 7'h00) begin miscompares++; $display("FAIL good_mask: got %b want 0000000", bus0.Fail_Mask); end
    vectors++; if (bus0.Pattern_Index !== 4'd10) begin miscompares++; $display("FAIL good_idx: got %0d want 10", bus0.Pattern_Index); end
    vectors++; if (bus0.A_out !== 7'h2A) begin miscompares++; $display("FAIL good_a: got %b want 0101010", bus0.A_out); end
  endtask

  task automatic test_stuck();
    int n;
    stuck0 = 7'h08;
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    wait_done0(n);
`ifdef TTL_SCAN_STOP_ON_FAIL_EN
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL stop_edges: got %0d want 8", n); end
    vectors++; if (bus0.Pattern_Index !== 4'd1) begin miscompares++; $display("FAIL stop_idx: got %0d want 1", bus0.Pattern_Index); end
    vectors++; if (bus0.A_out !== 7'h00) begin miscompares++; $display("FAIL stop_a: got %b want 0000000", bus0.A_out); end
`else
    vectors++; if (n !== 44) begin miscompares++; $display("FAIL stuck_edges: got %0d want 44", n); end
    vectors++; if (bus0.Pattern_Index !== 4'd10) begin miscompares++; $display("FAIL stuck_idx: got %0d want 10", bus0.Pattern_Index); end
`endif
    vectors++; if (bus0.Pass !== 1'b0) begin miscompares++; $display("FAIL stuck_pass: got %b want 0", bus0.Pass); end
    vectors++; if (bus0.Fail_Mask !== 7'h08) begin miscompares++; $display("FAIL stuck_mask: got %b want 0001000", bus0.Fail_Mask); end
  endtask

  task automatic test_back_to_back();
    int n;
    stuck0 = '0;
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    vectors++; if (bus0.Fail_Mask !== 7'h00) begin miscompares++; $display("FAIL b2b_mask_cleared: got %b want 0000000", bus0.Fail_Mask); end
    wait_done0(n);
    vectors++; if (n !== 44) begin miscompares++; $display("FAIL b2b_edges: got %0d want 44", n); end
    vectors++; if (bus0.Pass !== 1'b1) begin miscompares++; $display("FAIL b2b_pass: got %b want 1", bus0.Pass); end
  endtask

  task automatic test_clear_midrun();
    int n;
    stuck0 = 7'h08;
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    repeat (20) tick();
    #2 Clear = 1'b1;
    #1;
    vectors++; if (bus0.A_out !== 7'h00) begin miscompares++; $display("FAIL clr_a: got %b want 0000000", bus0.A_out); end
    vectors++; if (bus0.Busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy: got %b want 0", bus0.Busy); end
    vectors++; if (bus0.Done !== 1'b0) begin miscompares++; $display("FAIL clr_done: got %b want 0", bus0.Done); end
    vectors++; if (bus0.Fail_Mask !== 7'h00) begin miscompares++; $display("FAIL clr_mask: got %b want 0000000", bus0.Fail_Mask); end
    vectors++; if (bus0.Pattern_Index !== 4'd0) begin miscompares++; $display("FAIL clr_idx: got %0d want 0", bus0.Pattern_Index); end
    @(negedge Clk);
    Clear = 1'b0;
    stuck0 = '0;
    tick();
    bus0.Start = 1'b1;
    tick();
    bus0.Start = 1'b0;
    wait_done0(n);
    vectors++; if (n !== 44) begin miscompares++; $display("FAIL clr_rerun_edges: got %0d want 44", n); end
    vectors++; if (bus0.Pass !== 1'b1) begin miscompares++; $display("FAIL clr_rerun_pass: got %b want 1", bus0.Pass); end
  endtask

  task automatic test_start_held();
    int n;
    stuck0 = 7'h08;
    bus0.Start = 1'b1;
    tick();
    wait_done0(n);
`ifdef TTL_SCAN_STOP_ON_FAIL_EN
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL held_edges: got %0d want 8", n); end
`else
    vectors++; if (n !== 44) begin miscompares++; $display("FAIL held_edges: got %0d want 44", n); end
`endif
    vectors++; if (bus0.Fail_Mask !== 7'h08) begin miscompares++; $display("FAIL held_mask: got %b want 0001000", bus0.Fail_Mask); end
    tick();
    vectors++; if (bus0.Busy !== 1'b1) begin miscompares++; $display("FAIL held_restart_busy: got %b want 1", bus0.Busy); end
    vectors++; if (bus0.Done !== 1'b0) begin miscompares++; $display("FAIL held_restart_done: got %b want 0", bus0.Done); end
    vectors++; if (bus0.Fail_Mask !== 7'h00) begin miscompares++; $display("FAIL held_restart_mask: got %b want 0000000", bus0.Fail_Mask); end
    vectors++; if (bus0.Pattern_Index !== 4'd0) begin miscompares++; $display("FAIL held_restart_idx: got %0d want 0", bus0.Pattern_Index); end
    bus0.Start = 1'b0;
    stuck0 = '0;
    wait_done0(n);
    vectors++; if (n !== 44) begin miscompares++; $display("FAIL held_second_edges: got %0d want 44", n); end
    vectors++; if (bus0.Pass !== 1'b1) begin miscompares++; $display("FAIL held_second_pass: got %b want 1", bus0.Pass); end
  endtask

  task automatic test_settle0();
    int n;
    slow1 = 1'b0;
    bus1.Start = 1'b1;
    tick();
    bus1.Start = 1'b0;
    vectors++; if (bus1.Busy !== 1'b1) begin miscompares++; $display("FAIL s0_busy: got %b want 1", bus1.Busy); end
    wait_done1(n);
    vectors++; if (n !== 22) begin miscompares++; $display("FAIL s0_edges: got %0d want 22", n); end
    vectors++; if (bus1.Pass !== 1'b1) begin miscompares++; $display("FAIL s0_pass: got %b want 1", bus1.Pass); end
    vectors++; if (bus1.A_out !== 7'h2A) begin miscompares++; $display("FAIL s0_a: got %b want 0101010", bus1.A_out); end
    slow1 = 1'b1;
    bus1.Start = 1'b1;
    tick();
    bus1.Start = 1'b0;
    wait_done1(n);
`ifndef TTL_SCAN_STOP_ON_FAIL_EN
    vectors++; if (n !== 22) begin miscompares++; $display("FAIL s0_slow_edges: got %0d want 22", n); end
`endif
    vectors++; if ((bus1.Fail_Mask != 7'h00) !== 1'b1) begin miscompares++; $display("FAIL s0_slow_mask: got %b want nonzero", bus1.Fail_Mask); end
    vectors++; if (bus1.Pass !== 1'b0) begin miscompares++; $display("FAIL s0_slow_pass: got %b want 0", bus1.Pass); end
    slow1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stuck();
    test_back_to_back();
    test_clear_midrun();
    test_start_held();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
